memory_stage_ctrl: RTL
======================

// Module: memory_stage_ctrl
// PURPOSE
//  Parametrised MEM stage with its MEM/WB latch for the pipelined CPU.
//  Sequences one dcache request per instruction and holds it until dhit.
//  Buffers load data if WB cannot advance yet, and stalls upstream while a request is outstanding.
//  Sits between the EX/MEM latch and writeback; replaces the plain pass-through memory stage.
// PARAMETERS
//  DATA_W    32  data/word width; must be a multiple of 8
//  ADDR_W    32  dcache address width
//  REGSEL_W  2   writeback-source select width
//  REGBITS_W 5   destination register index width
// PORTS
//  CLK            in   1            clock, all state updates on rising edge
//  RST            in   1            synchronous, active-high reset
//  ihit           in   1            pipeline advance enable from icache
//  flush          in   1            bubble request for MEM/WB latch
//  nPC            in   ADDR_W       next-PC pass-through
//  dREN, dWEN     in   1            load / store request from EX/MEM
//  regWr          in   1            register write enable pass-through
//  regSel         in   REGSEL_W     writeback source pass-through
//  regDst         in   REGBITS_W    destination register pass-through
//  ALUOut         in   DATA_W       effective address / ALU result
//  rtdat          in   DATA_W       store data
//  memSize        in   2            00 byte, 01 half, 10 word (subword build only)
//  memSigned      in   1            sign-extend subword loads
//  dmemload       in   DATA_W       dcache read data
//  dhit           in   1            dcache completion, one-cycle pulse
//  dmemREN        out  1            dcache read request
//  dmemWEN        out  1            dcache write request
//  dmemaddr       out  ADDR_W       dcache address
//  dmemstore      out  DATA_W       dcache write data
//  dmemstrb       out  DATA_W/8     byte-lane write strobes
//  mem_stall      out  1            hold upstream latches
//  nPC_next, regWr_next, regSel_next, regDst_next, ALUOut_next   out   latched pass-throughs
//  dmemload_next  out  DATA_W       latched (extended) load data
// BEHAVIOUR
//  - Clock and reset: one clock CLK; reset RST is synchronous and active-high.
//  - FSM states: IDLE, WAIT, DONE.
//  - op = dREN|dWEN. dmemREN/dmemWEN = (state!=DONE) & dREN/dWEN.
//    The request is combinational: it asserts in the same cycle the op is presented.
//  - dmemaddr = word-aligned ALUOut.
//  - IDLE: op & !dhit -> WAIT. op & dhit & !ihit -> DONE.
//  - WAIT: hold the request; dhit & ihit -> IDLE; dhit & !ihit -> DONE.
//  - Every dhit latches the extended dmemload into the hold register.
//  - DONE: request deasserted, so there is never a second store. ihit -> IDLE.
//  - mem_stall = op & !dhit & (state!=DONE).
//  - MEM/WB latch loads only on adv = ihit & !mem_stall.
//  - Load data source: dhit ? dmemload : hold register.
//  - Non-memory ops advance on ihit with zero added latency.
//  - A load/store that hits in its first cycle causes 0 stall cycles.
//  - Flush: sampled only on adv. The latch loads a bubble:
//    regWr_next=0 and all other latch fields 0.
//  - Flush never aborts an outstanding request; the request completes before the bubble enters.
//  - Simultaneous flush and dhit: the access completes, the bubble is latched, and the FSM goes to IDLE.
//  - Reset (including mid-WAIT): state=IDLE, all latch outputs 0, hold register 0.
//    Requests drop the cycle after RST is sampled; the cache side tolerates the abandoned access.
// CONFIGURATION
//  MEM_SUBWORD_EN defined:
//  - Loads: byte/half lane selected by ALUOut[1:0] (half uses bit 1).
//    Zero-extended, or sign-extended when memSigned=1.
//  - Stores: rtdat is replicated across lanes and dmemstrb marks only the addressed lanes.
//  - Misaligned half (ALUOut[0]=1) or word (ALUOut[1:0]!=0): treated as a word access at the aligned address.
//  MEM_SUBWORD_EN undefined: memSize/memSigned ignored, dmemstrb all ones,
//    dmemload and rtdat pass unmodified.
// TESTING
//  1. RST=1 for 2 cycles with dREN=1 -> all *_next=0, and dmemREN=0 in the cycle after RST is sampled.
//  2. ALU op regWr=1, regDst=5, ALUOut=0x1234, ihit=1 -> next cycle regDst_next=5, ALUOut_next=0x1234, mem_stall never 1.
//  3. Load 0x40, dhit after 3 cycles with dmemload=0xDEADBEEF -> mem_stall=1 for 3 cycles, then dmemload_next=0xDEADBEEF.
//  4. Store with dhit while ihit=0 for 2 more cycles -> dmemWEN high for exactly one dhit, state DONE, single write.
//  5. flush=1 during WAIT -> request held until dhit, then regWr_next=0 latched.
//  6. MEM_SUBWORD_EN: lb at ALUOut=0x43, dmemload=0x80000000, memSigned=1 -> 0xFFFFFF80;
//     sb at 0x41 -> dmemstrb=4'b0010.

Source files
------------

// File: rtl/memory_stage_ctrl_if.sv
// Bundle of the EX/MEM inputs, the dcache port and the MEM/WB latch outputs for memory_stage_ctrl.
// The master modport is the memory stage's view; the slave modport is the surrounding pipeline/cache.
interface memory_stage_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REGSEL_W  = 2,
  parameter int REGBITS_W = 5
) ();
  logic                   ihit;
  logic                   flush;
  logic [ADDR_W-1:0]      nPC;
  logic                   dREN;
  logic                   dWEN;
  logic                   regWr;
  logic [REGSEL_W-1:0]    regSel;
  logic [REGBITS_W-1:0]   regDst;
  logic [DATA_W-1:0]      ALUOut;
  logic [DATA_W-1:0]      rtdat;
  logic [1:0]             memSize;
  logic                   memSigned;
  logic [DATA_W-1:0]      dmemload;
  logic                   dhit;

  logic                   dmemREN;
  logic                   dmemWEN;
  logic [ADDR_W-1:0]      dmemaddr;
  logic [DATA_W-1:0]      dmemstore;
  logic [DATA_W/8-1:0]    dmemstrb;
  logic                   mem_stall;

  logic [ADDR_W-1:0]      nPC_next;
  logic                   regWr_next;
  logic [REGSEL_W-1:0]    regSel_next;
  logic [REGBITS_W-1:0]   regDst_next;
  logic [DATA_W-1:0]      ALUOut_next;
  logic [DATA_W-1:0]      dmemload_next;

  modport master (
    input  ihit, flush, nPC, dREN, dWEN, regWr, regSel, regDst, ALUOut, rtdat,
           memSize, memSigned, dmemload, dhit,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dmemstrb, mem_stall,
           nPC_next, regWr_next, regSel_next, regDst_next, ALUOut_next, dmemload_next
  );

  modport slave (
    output ihit, flush, nPC, dREN, dWEN, regWr, regSel, regDst, ALUOut, rtdat,
           memSize, memSigned, dmemload, dhit,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmemstrb, mem_stall,
           nPC_next, regWr_next, regSel_next, regDst_next, ALUOut_next, dmemload_next
  );
endinterface

// File: rtl/memory_stage_ctrl.sv
// MEM stage + MEM/WB latch: one dcache request per instruction, held until dhit; stalls upstream meanwhile.
// Optional MEM_SUBWORD_EN adds byte/half loads (lane by ALUOut low bits) and strobed subword stores; needs DATA_W >= 32.
module memory_stage_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REGSEL_W  = 2,
  parameter int REGBITS_W = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  memory_stage_ctrl_if.master  bus
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic                op, not_done, adv;
  logic [DATA_W-1:0]   ld_ext, hold, st_dat;
  logic [NB-1:0]       strb;
  logic [ADDR_W-1:0]   addr_full;

  // Requests are gated by RST so an access in flight is dropped as soon as reset is seen.
  assign op       = (bus.dREN | bus.dWEN) & ~RST;
  assign not_done = (state != DONE);

  assign bus.dmemREN   = not_done & bus.dREN & ~RST;
  assign bus.dmemWEN   = not_done & bus.dWEN & ~RST;
  assign bus.mem_stall = op & ~bus.dhit & not_done;
  assign adv           = bus.ihit & ~bus.mem_stall;

  assign addr_full     = ADDR_W'(bus.ALUOut);
  assign bus.dmemaddr  = addr_full & ~(ADDR_W'(NB - 1));
  assign bus.dmemstore = st_dat;
  assign bus.dmemstrb  = strb;

`ifdef MEM_SUBWORD_EN
  localparam int OFF_W = $clog2(NB);
  logic [OFF_W-1:0] off;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign off    = bus.ALUOut[OFF_W-1:0];
  assign lane_b = 8'(bus.dmemload >> {off, 3'b000});
  assign lane_h = 16'(bus.dmemload >> {off[OFF_W-1:1], 4'b0000});

  always_comb begin
    ld_ext = bus.dmemload;
    st_dat = bus.rtdat;
    strb   = '1;
    case (bus.memSize)
      2'b00: begin
        ld_ext = {{(DATA_W-8){bus.memSigned & lane_b[7]}}, lane_b};
        st_dat = {NB{bus.rtdat[7:0]}};
        strb   = {{(NB-1){1'b0}}, 1'b1} << off;
      end
      2'b01: begin
        // Odd half addresses fall back to a full word at the aligned address.
        if (!off[0]) begin
          ld_ext = {{(DATA_W-16){bus.memSigned & lane_h[15]}}, lane_h};
          st_dat = {(NB/2){bus.rtdat[15:0]}};
          strb   = {{(NB-2){1'b0}}, 2'b11} << {off[OFF_W-1:1], 1'b0};
        end
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    ld_ext = bus.dmemload;
    st_dat = bus.rtdat;
    strb   = '1;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (op && !bus.dhit)              state_nxt = WAIT;
        else if (op && bus.dhit && !bus.ihit) state_nxt = DONE;
      end
      WAIT: begin
        if (bus.dhit) state_nxt = bus.ihit ? IDLE : DONE;
      end
      DONE: begin
        if (bus.ihit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Keeps the completed load data while WB is not ready to take it.
  always_ff @(posedge CLK) begin
    if (RST)           hold <= '0;
    else if (bus.dhit) hold <= ld_ext;
  end

  always_ff @(posedge CLK) begin
    if (RST || (adv && bus.flush)) begin
      bus.nPC_next      <= '0;
      bus.regWr_next    <= 1'b0;
      bus.regSel_next   <= '0;
      bus.regDst_next   <= '0;
      bus.ALUOut_next   <= '0;
      bus.dmemload_next <= '0;
    end else if (adv) begin
      bus.nPC_next      <= bus.nPC;
      bus.regWr_next    <= bus.regWr;
      bus.regSel_next   <= bus.regSel;
      bus.regDst_next   <= bus.regDst;
      bus.ALUOut_next   <= bus.ALUOut;
      bus.dmemload_next <= bus.dhit ? ld_ext : hold;
    end
  end

endmodule
